// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//
// MIPS pipeline IF stage. Holds the PC, selects the next PC (sequential,
// branch or jump), drives the word index into a combinational instruction
// ROM and captures the returned instruction plus PC+4 into the IF/ID register.
//
// Optional feature macro: FETCH_ADDR_CHECK_EN
//   defined   : out-of-range fetches (PC < TEXT_BASE or word index >= ROM_DEPTH)
//               drive ROM index 0, capture a bubble and set a sticky error flag.
//   undefined : raw word index is driven, no check, Addr_Error_out tied to 0.
//
// Ports
//   clk                in   single clock, all state on rising edge
//   reset              in   synchronous active-high reset
//   Stall_in           in   hold PC and IF/ID
//   Flush_in           in   load IF/ID with a bubble (NOP, valid=0)
//   Branch_taken_in    in   redirect PC to Branch_target_in
//   Branch_target_in   in   branch byte address (low 2 bits ignored)
//   Jump_in            in   redirect PC to Jump_target_in (beats branch)
//   Jump_target_in     in   jump byte address (low 2 bits ignored)
//   Rom_Address_out    out  word index into the ROM
//   Rom_Data_in        in   ROM read data, same cycle
//   PC_out             out  current PC register
//   IFID_Instr_out     out  registered instruction
//   IFID_PC_plus4_out  out  registered PC+4 of that instruction
//   IFID_Valid_out     out  IF/ID holds a real instruction
//   Addr_Error_out     out  sticky out-of-range fetch flag
// ----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int unsigned              BIT_WIDTH = 32,
    parameter logic [BIT_WIDTH-1:0]     TEXT_BASE = 32'h0040_0000,
    parameter int unsigned              ROM_DEPTH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Stall_in,
    input  logic                 Flush_in,
    input  logic                 Branch_taken_in,
    input  logic [BIT_WIDTH-1:0] Branch_target_in,
    input  logic                 Jump_in,
    input  logic [BIT_WIDTH-1:0] Jump_target_in,
    output logic [BIT_WIDTH-1:0] Rom_Address_out,
    input  logic [BIT_WIDTH-1:0] Rom_Data_in,
    output logic [BIT_WIDTH-1:0] PC_out,
    output logic [BIT_WIDTH-1:0] IFID_Instr_out,
    output logic [BIT_WIDTH-1:0] IFID_PC_plus4_out,
    output logic                 IFID_Valid_out,
    output logic                 Addr_Error_out
);

    // Parameter sanity checks, evaluated at elaboration only.
    if (BIT_WIDTH < 3) begin : g_bad_width
        $error("instruction_fetch_stage: BIT_WIDTH must be at least 3");
    end
    if (ROM_DEPTH == 0) begin : g_bad_depth
        $error("instruction_fetch_stage: ROM_DEPTH must be non-zero");
    end

    localparam logic [BIT_WIDTH-1:0] PcStep = BIT_WIDTH'(4);

    logic [BIT_WIDTH-1:0] pc_q, pc_d;
    logic [BIT_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [BIT_WIDTH-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic                 ifid_valid_q, ifid_valid_d;

    logic [BIT_WIDTH-1:0] pc_plus4;
    logic [BIT_WIDTH-1:0] word_index;
    logic                 fetch_ok;

    // Sequential PC; wraps naturally mod 2^BIT_WIDTH.
    assign pc_plus4   = pc_q + PcStep;
    assign word_index = (pc_q - TEXT_BASE) >> 2;

`ifdef FETCH_ADDR_CHECK_EN
    logic addr_error_q, addr_error_d;
    logic out_of_range;

    assign out_of_range = (pc_q < TEXT_BASE) || (word_index >= BIT_WIDTH'(ROM_DEPTH));
    assign fetch_ok     = ~out_of_range;

    always_comb begin
        addr_error_d = addr_error_q | out_of_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_error_q <= 1'b0;
        end else begin
            addr_error_q <= addr_error_d;
        end
    end

    assign Rom_Address_out = out_of_range ? '0 : word_index;
    assign Addr_Error_out  = addr_error_q;
`else
    assign fetch_ok        = 1'b1;
    assign Rom_Address_out = word_index;
    assign Addr_Error_out  = 1'b0;
`endif

    // Next PC: jump > branch > stall hold > sequential. Redirects win over stall.
    always_comb begin
        pc_d = pc_plus4;
        if (Jump_in) begin
            pc_d = {Jump_target_in[BIT_WIDTH-1:2], 2'b00};
        end else if (Branch_taken_in) begin
            pc_d = {Branch_target_in[BIT_WIDTH-1:2], 2'b00};
        end else if (Stall_in) begin
            pc_d = pc_q;
        end
    end

    // IF/ID: flush > stall hold > capture. A redirect alone does not squash the
    // instruction fetched this cycle; it is the delay slot.
    always_comb begin
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_valid_d    = ifid_valid_q;
        if (Flush_in) begin
            ifid_instr_d    = '0;
            ifid_pc_plus4_d = '0;
            ifid_valid_d    = 1'b0;
        end else if (!Stall_in) begin
            ifid_pc_plus4_d = pc_plus4;
            if (fetch_ok) begin
                ifid_instr_d = Rom_Data_in;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_instr_d = '0;
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= TEXT_BASE;
            ifid_instr_q    <= '0;
            ifid_pc_plus4_q <= '0;
            ifid_valid_q    <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end

    assign PC_out            = pc_q;
    assign IFID_Instr_out    = ifid_instr_q;
    assign IFID_PC_plus4_out = ifid_pc_plus4_q;
    assign IFID_Valid_out    = ifid_valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//
// Directed scenarios followed by randomized stimulus, all checked against a
// behavioural model of the fetch stage kept in this file. Honours the
// FETCH_ADDR_CHECK_EN macro the same way the design does.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

    localparam logic [31:0] Base  = 32'h0040_0000;
    localparam int unsigned Depth = 128;

    logic        clk;
    logic        reset;
    logic        stall, flush, br_taken, jump;
    logic [31:0] br_target, jump_target;
    logic [31:0] rom_addr, rom_data;
    logic [31:0] pc_out, ifid_instr, ifid_p4;
    logic        ifid_valid, addr_err;

    logic [31:0] rom [Depth];

    int unsigned n_total;
    int unsigned n_bad;

    // Model state: the architectural values after the most recent edge.
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid, m_err;

    instruction_fetch_stage #(
        .BIT_WIDTH (32),
        .TEXT_BASE (Base),
        .ROM_DEPTH (Depth)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .Stall_in          (stall),
        .Flush_in          (flush),
        .Branch_taken_in   (br_taken),
        .Branch_target_in  (br_target),
        .Jump_in           (jump),
        .Jump_target_in    (jump_target),
        .Rom_Address_out   (rom_addr),
        .Rom_Data_in       (rom_data),
        .PC_out            (pc_out),
        .IFID_Instr_out    (ifid_instr),
        .IFID_PC_plus4_out (ifid_p4),
        .IFID_Valid_out    (ifid_valid),
        .Addr_Error_out    (addr_err)
    );

    // Combinational ROM; indices past the end return a recognisable pattern.
    assign rom_data = (rom_addr < Depth) ? rom[rom_addr[6:0]] : ~rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx < Depth) return rom[idx[6:0]];
        return ~idx;
    endfunction

    function automatic logic in_range(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - Base;
        return (pc >= Base) && ((off / 4) < Depth);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_idx;
        exp_idx = (m_pc - Base) / 4;
`ifdef FETCH_ADDR_CHECK_EN
        if (!in_range(m_pc)) exp_idx = 32'd0;
        check_val("addr_err", {31'd0, addr_err}, {31'd0, m_err});
`else
        check_val("addr_err", {31'd0, addr_err}, 32'd0);
`endif
        check_val("pc", pc_out, m_pc);
        check_val("rom_addr", rom_addr, exp_idx);
        check_val("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        check_val("instr", ifid_instr, m_instr);
        if (m_valid) check_val("pc_plus4", ifid_p4, m_p4);
    endtask

    // Apply one cycle of inputs (at a falling edge), advance the model, and
    // compare at the next falling edge.
    task automatic step(input logic rst, input logic st, input logic fl, input logic br,
                        input logic [31:0] bt, input logic j, input logic [31:0] jt);
        logic        ok;
        logic [31:0] seq;
        reset = rst; stall = st; flush = fl;
        br_taken = br; br_target = bt; jump = j; jump_target = jt;
        if (rst) begin
            m_pc = Base; m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
`ifdef FETCH_ADDR_CHECK_EN
            ok = in_range(m_pc);
`else
            ok = 1'b1;
`endif
            seq = m_pc + 32'd4;
            if (fl) begin
                m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0;
            end else if (!st) begin
                m_p4    = seq;
                m_valid = ok;
                m_instr = ok ? rom_word((m_pc - Base) / 4) : 32'd0;
            end
            if (!ok) m_err = 1'b1;
            if (j)       m_pc = jt & ~32'd3;
            else if (br) m_pc = bt & ~32'd3;
            else if (!st) m_pc = seq;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_plain();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        logic        r_rst, r_st, r_fl, r_br, r_j;
        logic [31:0] r_bt, r_jt;
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        br_taken = 1'b0; jump = 1'b0; br_target = 32'd0; jump_target = 32'd0;
        for (int i = 0; i < Depth; i++) rom[i] = $urandom;
        rom[0] = 32'h2008_0005;
        m_pc = Base; m_instr = 32'd0; m_p4 = 32'd0; m_valid = 1'b0; m_err = 1'b0;
        @(negedge clk);

        // Reset held for two cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val("rst_pc", pc_out, 32'h0040_0000);
        check_val("rst_rom_addr", rom_addr, 32'd0);
        check_val("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check_val("rst_instr", ifid_instr, 32'd0);

        // First fetch.
        run_plain();
        check_val("t2_instr", ifid_instr, 32'h2008_0005);
        check_val("t2_p4", ifid_p4, 32'h0040_0004);
        check_val("t2_pc", pc_out, 32'h0040_0004);
        check_val("t2_rom_addr", rom_addr, 32'd1);

        // Stall at 0x00400008 for two cycles, then resume.
        run_plain();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val("t3_pc_hold", pc_out, 32'h0040_0008);
        check_val("t3_idx_hold", rom_addr, 32'd2);
        run_plain();
        check_val("t3_resume_instr", ifid_instr, rom[2]);

        // Branch keeps the delay slot; branch with flush squashes it.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 32'd0);
        check_val("t4_pc", pc_out, 32'h0040_0020);
        check_val("t4_rom_addr", rom_addr, 32'd8);
        check_val("t4_valid", {31'd0, ifid_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b0, 32'd0);
        check_val("t4f_instr", ifid_instr, 32'd0);
        check_val("t4f_valid", {31'd0, ifid_valid}, 32'd0);

        // Jump beats branch and stall; target alignment.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0040);
        check_val("t5_pc", pc_out, 32'h0040_0040);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0043);
        check_val("t5_align", pc_out, 32'h0040_0040);

        // Flush + stall: bubble, PC held.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val("fs_pc", pc_out, 32'h0040_0040);

        // Jump just past the ROM.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0200);
`ifdef FETCH_ADDR_CHECK_EN
        check_val("t6_rom_addr", rom_addr, 32'd0);
`else
        check_val("t6_rom_addr", rom_addr, 32'd128);
`endif
        run_plain();
        run_plain();
`ifdef FETCH_ADDR_CHECK_EN
        check_val("t6_err", {31'd0, addr_err}, 32'd1);
        check_val("t6_valid", {31'd0, ifid_valid}, 32'd0);
`else
        check_val("t6_err", {31'd0, addr_err}, 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0010);
        run_plain();

        // PC+4 wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        run_plain();
        check_val("wrap_pc", pc_out, 32'd0);

        // Reset overrides a stalled redirect.
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0040);
        check_val("rst_ovr_pc", pc_out, 32'h0040_0000);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_br  = ($urandom_range(0, 7) == 0);
            r_j   = ($urandom_range(0, 9) == 0);
            r_bt  = Base + $urandom_range(0, 32'h220);
            r_jt  = ($urandom_range(0, 15) == 0) ? $urandom : Base + $urandom_range(0, 32'h220);
            step(r_rst, r_st, r_fl, r_br, r_bt, r_j, r_jt);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
